// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a valid/ack byte handshake.
// Define UART_RX_PARITY_EN to expect one even-parity bit per frame (8E1).
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BREAK  = 3'd5;

  logic                 rx_meta;
  logic                 rx_s;
  logic [2:0]           state;
  logic [TW-1:0]        timer;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 deliver_p;
  logic                 ferr_p;
  logic                 perr_p;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] v);
    return ^v;
  endfunction

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame state machine; results are staged in *_p and published one cycle later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      timer     <= '0;
      idx       <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      deliver_p <= 1'b0;
      ferr_p    <= 1'b0;
      perr_p    <= 1'b0;
    end else begin
      deliver_p <= 1'b0;
      ferr_p    <= 1'b0;
      perr_p    <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (timer == HALF_LAST) begin
            timer <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        DATA: begin
          if (timer == BIT_LAST) begin
            timer      <= '0;
            shift[idx] <= rx_s;
            idx        <= idx + IDX_ONE;
            if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (timer == BIT_LAST) begin
            timer   <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
`endif
        STOP: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
`ifdef UART_RX_PARITY_EN
            perr_p <= (even_parity(shift) != par_bit);
`endif
            if (rx_s) begin
              deliver_p <= 1'b1;
              state     <= IDLE;
            end else begin
              ferr_p <= 1'b1;
              state  <= BREAK;
            end
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        BREAK: begin
          timer <= '0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  // Output register: delivery beats a simultaneous ack, and overruns only an unacked byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      frame_err  <= ferr_p;
      parity_err <= perr_p;
      overrun    <= 1'b0;
      if (deliver_p) begin
        data       <= shift;
        data_valid <= 1'b1;
        overrun    <= data_valid && !data_ack;
      end else if (data_valid && data_ack) begin
        data_valid <= 1'b0;
      end else begin
        data_valid <= data_valid;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; honours UART_RX_PARITY_EN.
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       data_ack = 1'b0;
  logic [7:0] data;
  logic       data_valid, frame_err, overrun, parity_err, busy;

  int n_checks = 0;
  int n_errs = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_perr = 0;
  int base;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .data_valid(data_valid),
    .data_ack(data_ack), .frame_err(frame_err), .overrun(overrun),
    .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse counters: a one-cycle pulse adds exactly one.
  always @(negedge clk) begin
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (parity_err) n_perr++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Stop sample lands 11 edges into the stop bit; ack_dlv raises ack for the delivery edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic par_flip, input logic ack_dlv);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
`ifdef UART_RX_PARITY_EN
    hold((^b) ^ par_flip, CPB);
`endif
    if (ack_dlv) begin
      hold(stop_bit, 11);
      data_ack = 1'b1;
      @(posedge clk);
      #1;
      data_ack = 1'b0;
      hold(stop_bit, CPB - 12);
    end else begin
      hold(stop_bit, CPB);
    end
    rx = 1'b1;
  endtask

  task automatic do_ack();
    data_ack = 1'b1;
    @(posedge clk);
    #1;
    data_ack = 1'b0;
    @(negedge clk);
    check("ack_clears_valid", {31'd0, data_valid}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_data", {24'd0, data}, 32'h0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_perr", {31'd0, parity_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    hold(1'b1, 5);

    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check("basic_valid", {31'd0, data_valid}, 32'd1);
    check("basic_data", {24'd0, data}, 32'hA5);
    do_ack();

    base = n_ferr;
    hold(1'b0, 5);
    hold(1'b1, 9);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_valid", {31'd0, data_valid}, 32'd0);
    check("glitch_ferr", n_ferr - base, 32'd0);
    hold(1'b1, 10);

    base = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    hold(1'b0, 24);
    hold(1'b1, 20);
    check("ferr_pulses", n_ferr - base, 32'd1);
    check("ferr_no_valid", {31'd0, data_valid}, 32'd0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    check("after_ferr_valid", {31'd0, data_valid}, 32'd1);
    check("after_ferr_data", {24'd0, data}, 32'h55);
    do_ack();

    base = n_ovr;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    hold(1'b1, 4);
    check("ovr_pulses", n_ovr - base, 32'd1);
    check("ovr_data", {24'd0, data}, 32'h22);
    do_ack();

    base = n_ovr;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b1);
    hold(1'b1, 4);
    check("coll_no_ovr", n_ovr - base, 32'd0);
    check("coll_valid", {31'd0, data_valid}, 32'd1);
    check("coll_data", {24'd0, data}, 32'h22);

    // data_valid is still 1 here, so the reset must visibly clear it.
    base = n_ferr + n_ovr + n_perr;
    hold(1'b0, CPB);
    for (int i = 0; i < 3; i++) hold(1'b0, CPB);
    hold(1'b0, 8);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    rx = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mrst_data", {24'd0, data}, 32'h0);
    check("mrst_valid", {31'd0, data_valid}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    hold(1'b1, 20);
    check("mrst_no_pulse", n_ferr + n_ovr + n_perr - base, 32'd0);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
    check("mrst_next_valid", {31'd0, data_valid}, 32'd1);
    check("mrst_next_data", {24'd0, data}, 32'h7E);
    do_ack();

`ifdef UART_RX_PARITY_EN
    base = n_perr;
    send_frame(8'h03, 1'b1, 1'b0, 1'b0);
    check("par_ok_valid", {31'd0, data_valid}, 32'd1);
    check("par_ok_perr", n_perr - base, 32'd0);
    do_ack();
    send_frame(8'h03, 1'b1, 1'b1, 1'b0);
    check("par_bad_perr", n_perr - base, 32'd1);
    check("par_bad_valid", {31'd0, data_valid}, 32'd1);
    check("par_bad_data", {24'd0, data}, 32'h03);
    do_ack();
`else
    check("no_parity_err", n_perr, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver; the receiving end of the CPU's `tx` line.
- Deserialises 8N1 frames (8E1 with the option below), sampling at mid-bit from a clock-divided bit timer.
- Presents each byte with a valid/ack handshake.
- Used by the test bench and by a host-side loopback to check CPU serial output.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit (100 MHz / 115200); legal range 4 to 65535.
- DATA_BITS, 8, data bits per frame, sent LSB first; legal range 5 to 8.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- rx  in  1  asynchronous serial input; idle high.
- data  out  DATA_BITS  received byte; stable while data_valid=1.
- data_valid  out  1  byte available; held until acknowledged.
- data_ack  in  1  consumer accepts byte; effective only when data_valid=1.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: new byte completed while data_valid still 1.
- parity_err  out  1  one-cycle pulse: parity mismatch; constant 0 without the option.
- busy  out  1  1 whenever state is not IDLE.

Behaviour:
- Reset (rst=0 on a rising edge) values:
  - data=0, data_valid=0, frame_err=0, overrun=0, parity_err=0, busy=0.
  - Synchroniser flops = 1, state=IDLE, bit timer=0, bit index=0.
- Reset mid-frame aborts the frame; no output pulses are produced.
- Synchroniser: rx passes through 2 flops to give rx_s. The state machine uses only rx_s, so there are 2 cycles of input latency.
- States and transitions:
  - IDLE: rx_s=0 -> START; timer cleared.
  - START: count to CLKS_PER_BIT/2-1 (integer division).
    - rx_s=0 at that count -> DATA; timer cleared; index=0.
    - rx_s=1 at that count is a glitch -> IDLE; no pulse.
  - DATA: every CLKS_PER_BIT cycles, shift rx_s into shift[index] and increment index.
    - After bit DATA_BITS-1 -> PARITY if the option is compiled in, otherwise STOP.
  - PARITY (option only): sample after CLKS_PER_BIT cycles -> STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rx_s=1 -> deliver byte, go to IDLE.
    - rx_s=0 -> frame_err pulse, byte discarded, go to BREAK.
  - BREAK: wait for rx_s=1 -> IDLE. Holds off false starts during a line break.
- Delivery, in the cycle after the stop sample:
  - data <= shift; data_valid <= 1.
  - If data_valid was already 1 and data_ack=0 in that cycle: overrun pulses and data is overwritten with the new byte.
- Handshake:
  - data_ack=1 while data_valid=1 clears data_valid on the next edge.
  - Delivery and ack in the same cycle: delivery wins (data_valid stays 1, new data loaded, no overrun).
  - data_ack while data_valid=0 is ignored.
- Timer: width $clog2(CLKS_PER_BIT)+1; counts 0..CLKS_PER_BIT-1, then wraps to 0. It never free-runs in IDLE.
- Back-to-back frames: a start edge immediately after the stop sample is accepted; the IDLE dwell can be one cycle.
- Error pulses are exactly one cycle wide and mutually independent. parity_err and frame_err may both pulse for the same frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Each frame carries one even-parity bit after the data bits; the PARITY state is present.
  - Mismatch -> parity_err pulses in the delivery cycle. The byte is still delivered if the stop bit is good.
- Undefined:
  - No PARITY state; frames are 8N1.
  - parity_err is tied to 0.

Test Plan:
- Basic receive: CLKS_PER_BIT=16; drive 0xA5 as 8N1 at 16 clk/bit -> data=0xA5 and data_valid=1 within 2+8 cycles after the stop-bit midpoint. data_ack=1 -> data_valid=0 on the next edge.
- Glitch rejection: rx low for 5 cycles, then high -> state returns to IDLE; no data_valid, no frame_err; busy is 0 again by cycle 12.
- Framing error: send 0x3C with stop bit=0, held low for 40 cycles, then high, then send 0x55 -> one frame_err pulse; no data_valid for 0x3C; 0x55 received correctly.
- Overrun and collision: send 0x11 then 0x22 without ack -> overrun pulses once, data=0x22. Repeat with ack asserted in the delivery cycle -> no overrun, data_valid=1, data=0x22.
- Reset mid-frame: rst=0 for one edge during DATA bit 3 -> all outputs 0 and busy=0; next 0x7E frame received correctly.
- Parity (UART_RX_PARITY_EN defined): 0x03 with parity bit 0 -> data_valid, parity_err=0. 0x03 with parity bit 1 -> parity_err pulse and byte delivered. Undefined build: parity_err never asserts.
